// File: rtl/mux_stream_rr.sv
// mux_stream_rr: registered N-to-1 valid/ready stream multiplexer.
// Channel choice is either a fixed select (mode=0, port S) or round-robin
// among valid channels (mode=1), starting at a rotating pointer.
// A single output register; a new word may be loaded in the same cycle the
// held word drains, so sustained throughput is one word per cycle.
// Optional feature: define MUX_STREAM_RR_XFER_CNT_EN to add a 16-bit count
// of output handshakes (xfer_cnt) with a synchronous clear (cnt_clr).
module mux_stream_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            E,
  input  logic            mode,
  input  logic [SW-1:0]   S,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_chan
`ifdef MUX_STREAM_RR_XFER_CNT_EN
  ,
  output logic [15:0]     xfer_cnt,
  input  logic            cnt_clr
`endif
);

  logic [SW-1:0] ptr_r;
  logic [W-1:0]  out_data_r;
  logic          out_valid_r;
  logic [SW-1:0] out_chan_r;

  logic          load_s;
  logic          grant_vld_s;
  logic [SW-1:0] grant_idx_s;
  logic [W-1:0]  grant_data_s;
  logic [N-1:0]  in_ready_s;
  logic          xfer_s;
  logic [SW-1:0] next_ptr_s;

  // Output register can take a word when enabled and empty or draining;
  // rst_n is folded in so no ready is offered while reset is asserted.
  always_comb begin
    load_s = rst_n & E & (~out_valid_r | out_ready);
  end

  // Grant selection: fixed select or round-robin search from ptr with wrap.
  always_comb begin
    logic [SW:0]   sum_v;
    logic [SW-1:0] cand_v;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    sum_v       = '0;
    cand_v      = '0;
    case (mode)
      1'b0: begin
        if (int'(S) < N) begin
          if (in_valid[S]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = S;
          end else begin
            grant_vld_s = 1'b0;
          end
        end else begin
          grant_vld_s = 1'b0;
        end
      end
      1'b1: begin
        for (int k = 0; k < N; k++) begin
          sum_v = {1'b0, ptr_r} + (SW+1)'(k);
          if (sum_v >= (SW+1)'(N)) begin
            sum_v = sum_v - (SW+1)'(N);
          end else begin
            sum_v = sum_v;
          end
          cand_v = sum_v[SW-1:0];
          if (!grant_vld_s && in_valid[cand_v]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = cand_v;
          end else begin
            grant_vld_s = grant_vld_s;
          end
        end
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
      end
    endcase
  end

  // Data word of the granted channel (constant-index slices only).
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx_s == SW'(i)) begin
        grant_data_s = in_data[i*W +: W];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Ready goes only to the granted channel; transfer and next pointer.
  always_comb begin
    in_ready_s = '0;
    if (grant_vld_s) begin
      in_ready_s[grant_idx_s] = load_s;
    end else begin
      in_ready_s = '0;
    end
    xfer_s = grant_vld_s & load_s;
    if (grant_idx_s == SW'(N-1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + SW'(1);
    end
  end

  // Output register and round-robin pointer; ptr moves only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_chan_r  <= '0;
      ptr_r       <= '0;
    end else if (xfer_s) begin
      out_data_r  <= grant_data_s;
      out_valid_r <= 1'b1;
      out_chan_r  <= grant_idx_s;
      ptr_r       <= next_ptr_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef MUX_STREAM_RR_XFER_CNT_EN
  logic [15:0] xfer_cnt_r;

  // Output handshake counter; clear wins over increment, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_r <= 16'h0000;
    end else if (cnt_clr) begin
      xfer_cnt_r <= 16'h0000;
    end else if (out_valid_r && out_ready) begin
      xfer_cnt_r <= xfer_cnt_r + 16'h0001;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr: a reference model (grant rules written with
// modulo arithmetic, one held-word record) is compared with the DUT on every
// falling edge, plus directed literal checks that pin the model.
module tb_mux_stream_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           E = 1'b0;
  logic           mode = 1'b0;
  logic [SW-1:0]  S = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_chan;
`ifdef MUX_STREAM_RR_XFER_CNT_EN
  logic [15:0]    xfer_cnt;
  logic           cnt_clr = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  mux_stream_rr #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .S(S),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
`ifdef MUX_STREAM_RR_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt), .cnt_clr(cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int          m_chan  = 0;
  logic [15:0] m_cnt   = 16'h0000;

  int          e_grant;
  logic        e_load;
  logic [N-1:0] e_ready;

  function automatic int pick(input logic md, input int sel, input logic [N-1:0] v, input int p);
    if (md == 1'b0) begin
      if (sel < N && v[sel]) return sel;
      return -1;
    end
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always_comb begin
    e_grant = pick(mode, int'(S), in_valid, m_ptr);
    e_load  = rst_n & E & (!m_valid | out_ready);
    e_ready = '0;
    if (e_grant >= 0 && e_load) e_ready = N'(1) << e_grant;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_valid <= 1'b0; m_data <= '0; m_chan <= 0; m_cnt <= 16'h0000;
    end else begin
      if (e_grant >= 0 && e_load) begin
        m_valid <= 1'b1;
        m_data  <= in_data[e_grant*W +: W];
        m_chan  <= e_grant;
        m_ptr   <= (e_grant + 1) % N;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
`ifdef MUX_STREAM_RR_XFER_CNT_EN
      if (cnt_clr) m_cnt <= 16'h0000;
      else if (m_valid && out_ready) m_cnt <= m_cnt + 16'h0001;
`endif
    end
  end

  // Compare process: outputs are stable and inputs settled at the falling edge.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_chan",  32'(out_chan),  32'(m_chan));
    chk("in_ready",  32'(in_ready),  32'(e_ready));
`ifdef MUX_STREAM_RR_XFER_CNT_EN
    chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_seq(input string name, input int n, input int exp_seq[8]);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk(name, 32'(out_chan), 32'(exp_seq[i]));
    end
  endtask

  initial begin
    int seq_all[8];
    int seq_13[8];
    seq_all = '{0, 1, 2, 3, 0, 1, 2, 3};
    seq_13  = '{1, 3, 1, 3, 0, 0, 0, 0};

    // Reset with all channels valid and enable high.
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1111;
    E = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);

    // Release: round-robin, first grant is channel 0.
    rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1;
    #1 chk("first_ready", 32'(in_ready), 32'h1);
    #1;
    // Fairness with all valid: 0,1,2,3,0,1,2,3.
    run_seq("rr_all", 8, seq_all);
    chk("rr_first_data", 32'(out_data), 32'h44);

    // Only channels 1 and 3 valid.
    in_valid = 4'b1010;
    run_seq("rr_13", 4, seq_13);

    // Fixed select, S=2.
    mode = 1'b0; S = 2'd2; in_valid = 4'b0100;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1 chk("fix_ready", 32'(in_ready), 32'h4);
    tick();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_chan", 32'(out_chan), 32'd2);
    // S=1 while only ch2 valid: no grant, output drains.
    S = 2'd1;
    #1 chk("fix_noready", 32'(in_ready), 32'h0);
    tick();
    chk("fix_drop", 32'(out_valid), 32'd0);
    chk("fix_hold", 32'(out_data), 32'hA5);

    // Backpressure: load ch1, then stall three cycles.
    in_valid = 4'b0010; in_data = {8'h44, 8'hA5, 8'h5A, 8'h11};
    tick();
    chk("bp_load", 32'(out_data), 32'h5A);
    out_ready = 1'b0; S = 2'd0; in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_stable", 32'(out_data), 32'h5A);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    // Drain and load together: no bubble.
    out_ready = 1'b1;
    #1 chk("dl_ready", 32'(in_ready), 32'h1);
    tick();
    chk("dl_valid", 32'(out_valid), 32'd1);
    chk("dl_data", 32'(out_data), 32'h11);
    chk("dl_chan", 32'(out_chan), 32'd0);

    // Enable low: no grants, held word drains, ptr (now 1) frozen.
    E = 1'b0; mode = 1'b1; in_valid = 4'b1111;
    #1 chk("en_ready", 32'(in_ready), 32'h0);
    tick();
    chk("en_drain", 32'(out_valid), 32'd0);
    tick();
    chk("en_idle", 32'(out_valid), 32'd0);
    E = 1'b1;
    #1 chk("en_resume_ready", 32'(in_ready), 32'h2);
    tick();
    chk("en_resume_chan", 32'(out_chan), 32'd1);

    // Reset mid-transfer discards the held word immediately.
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1 chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("midrst_ready", 32'(in_ready), 32'h1);

`ifdef MUX_STREAM_RR_XFER_CNT_EN
    // First cycle loads, next five each complete a handshake.
    repeat (6) tick();
    chk("cnt_five", 32'(xfer_cnt), 32'd5);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr", 32'(xfer_cnt), 32'd0);
    cnt_clr = 1'b0;
    repeat (65535) tick();
    chk("cnt_max", 32'(xfer_cnt), 32'hFFFF);
    tick();
    chk("cnt_wrap", 32'(xfer_cnt), 32'd0);
`else
    repeat (4) tick();
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised, registered N-to-1 stream multiplexer with enable; successor of the combinational 4:1 enable-gated mux.
- Takes N valid/ready input channels of W bits each and forwards one word per accepted transfer to a single registered output.
- Channel selection is either fixed-select (select port, like a classic mux) or round-robin arbitration among valid channels.
- Used wherever several producers share one downstream consumer.

Parameters:
- N, 4, number of input channels (>=2).
- W, 8, data width per channel.
- SW, $clog2(N), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- E  input  1  enable; 0 blocks new grants.
- mode  input  1  0 = fixed select via S; 1 = round-robin.
- S  input  SW  channel select, used when mode=0.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (one-hot or zero).
- out_data  output  W  registered output word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts out_data.
- out_chan  output  SW  index of channel that supplied out_data.

Behaviour:
- One output register, no skid buffer.
- load = E & (~out_valid | out_ready).
- Grant selection, computed combinationally each cycle:
  - mode=0: grant = S when S < N and in_valid[S]=1; otherwise no grant.
  - mode=1: grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N); no grant if none are valid.
- in_ready[grant] = load; all other in_ready bits = 0. in_ready must not depend on in_valid of other channels in mode=0.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= channel i data.
  - out_chan <= i.
  - out_valid <= 1.
  - ptr <= (i == N-1) ? 0 : i+1.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_chan hold their values.
- No transfer and out_ready=0: output register holds.
- Latency: input transfer to out_valid is 1 cycle. Sustained throughput is 1 word/cycle while out_ready=1.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, out_valid stays 1, no bubble.
- E=0: no grants and ptr frozen; a word already held still drains normally.
- ptr updates in both modes. Switching mode takes effect in the same cycle's grant computation; ptr is retained across mode switches.
- Round-robin fairness: with all N channels valid continuously and out_ready=1, grants cycle 0,1,...,N-1,0,...
- S >= N (N not a power of two): no grant, all in_ready=0.
- Reset (asynchronous assert, synchronous to clk on deassert externally):
  - out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0 while rst_n=0.
  - Reset mid-transfer discards the held word.

Optional Feature:
- Macro: MUX_STREAM_RR_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt [15:0], reset 0.
  - Increments by 1 on every output handshake (out_valid & out_ready); wraps 0xFFFF -> 0.
  - Adds input cnt_clr (1 bit); synchronous clear to 0, which takes priority over increment.
- Not defined: neither port exists and the rest of the block is unchanged.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0. Release, E=1, mode=1 -> first grant is channel 0; out_chan=0 one cycle later.
- Fixed select: mode=0, S=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2. Repeat with S=1 while only ch2 is valid -> in_ready=0, out_valid drops to 0.
- Round-robin: mode=1, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3. Channels 1 and 3 only valid -> sequence 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data stable. out_ready=1 with ch0 valid -> drain and load in the same cycle, out_valid stays 1.
- Enable: E=0 with all valid -> no in_ready asserted and a held word drains once. E=1 -> arbitration resumes from the frozen ptr.
- Counter (macro defined): 5 output handshakes -> xfer_cnt=5. cnt_clr asserted together with a handshake -> xfer_cnt=0. Preload to 0xFFFF by driving traffic, then one more handshake -> wraps to 0.
